vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Monitor-side decoder for the porch-shaped VGA stream that the team's sync/porch pipeline produces. It accepts active-low `hsync`/`vsync` pulses plus RGB, recovers column and row position, and locks to the expected timing through a frame-level state machine. It emits an active-video enable, pixel coordinates and blanked RGB. It sits at the input of any capture, checker or loopback logic that consumes our VGA output.

## Interface
- `VIDEO_WIDTH`, 3, bits per colour channel
- `CNT_WIDTH`, 10, width of the column/row counters; must hold `TOTAL_COLS-1` and `TOTAL_ROWS-1`
- `TOTAL_COLS`, 800, clocks per line
- `TOTAL_ROWS`, 525, lines per frame
- `ACTIVE_COLS`, 640, visible pixels per line
- `ACTIVE_ROWS`, 480, visible lines per frame
- `FRONT_PORCH_HORZ`, 18; `BACK_PORCH_HORZ`, 50; `FRONT_PORCH_VERT`, 10; `BACK_PORCH_VERT`, 33
- `LOCK_FRAMES`, 2, consecutive error-free frames needed to lock (≥1)
- `clk`  in  1  pixel clock
- `rst_n`  in  1  synchronous, active-low reset
- `i_hsync`, `i_vsync`  in  1  active-low sync pulses
- `i_r_val`, `i_g_val`, `i_b_val`  in  `VIDEO_WIDTH`  pixel colour
- `o_r_val`, `o_g_val`, `o_b_val`  out  `VIDEO_WIDTH`  colour, forced to 0 when `o_active`=0
- `o_col`, `o_row`  out  `CNT_WIDTH`  recovered pixel position
- `o_active`  out  1  visible pixel and locked
- `o_frame_start`  out  1  one-cycle pulse with pixel (0,0) while locked
- `o_locked`  out  1  timing lock indicator

## Operation
- Line layout, in columns: active `0..AC-1`, front porch `AC..AC+FPH-1`, sync `AC+FPH..TC-BPH-1`, back porch `TC-BPH..TC-1`. Rows use the same layout with the vertical parameters.
- `H_SYNC_COL = ACTIVE_COLS+FRONT_PORCH_HORZ`; `V_SYNC_ROW = ACTIVE_ROWS+FRONT_PORCH_VERT`.
- All inputs are registered once. A falling edge is registered sample 0 while the prior registered sample is 1.
- Column counter: free-runs and wraps `TC-1 → 0`. On an hsync fall it is loaded with `H_SYNC_COL`.
- Row counter: increments when the column wraps, and wraps `TR-1 → 0`. On a vsync fall it is loaded with `V_SYNC_ROW`.
- h-error: an hsync fall while the free-running column would not already have been `H_SYNC_COL`.
- v-error: a vsync fall while the row would not already have been `V_SYNC_ROW`.
- Timeout: no hsync fall for `2*TOTAL_COLS` clocks; this counts as an error.
- FSM states and transitions:
  - SEARCH: counters hold 0 until the first vsync fall, which loads the counters and moves to ACQUIRE with good-count = 0. The first hsync fall also loads the column counter.
  - ACQUIRE: on each vsync fall, if there has been no error since the previous vsync fall, good-count increments; otherwise good-count clears. Reaching `LOCK_FRAMES` moves to LOCKED.
  - LOCKED: any error moves to SEARCH on the next cycle.
- `o_locked` is 1 only in LOCKED.
- `o_active = locked && col<AC && row<AR`.
- `o_frame_start = locked && col==0 && row==0`.
- Simultaneous h- and v-fall on the same sample: both loads apply and both checks apply.
- An error and a vsync fall in the same cycle in ACQUIRE: good-count clears.

## Timing
- Latency is 2 clocks from input pins to every output. The sample taken on the first clock `i_hsync` is low (cycle T) appears at T+2 with `o_col = H_SYNC_COL`.
- RGB is delayed by exactly the same 2 stages as the position and enables.
- Reset (`rst_n`=0 at a clock edge): the FSM goes to SEARCH; counters, good-count, timeout and edge history go to 0; the sync history goes to 1. All outputs are 0 on the following cycle.
- Reset asserted mid-frame while LOCKED drops `o_locked` within 1 clock. Reacquiring after release needs at least `LOCK_FRAMES+1` vsync falls.
- Loss of lock: the error is detected at the output stage. `o_locked`, `o_active` and RGB are 0 starting the cycle after the erroneous sample reaches the output.

## Test plan
Small parameters: TC=16, AC=8, FPH=2, BPH=3, TR=12, AR=6, FPV=1, BPV=2, LOCK_FRAMES=2.
- Clean frames from reset: `o_locked` rises at the 3rd vsync fall + 2 clocks. After that, `o_active` is high for 8 clocks per line on rows 0–5, and `o_frame_start` pulses once per 192 clocks.
- Locked pixel check: drive RGB = column index. At output col 3 row 2, `o_r_val`=3. At col 9 (porch), RGB = 0.
- Early hsync: while locked, one hsync fall arrives 1 clock early. `o_locked` falls, re-lock happens after 2 further clean frames, and `o_col` re-aligns to 10 at that hsync.
- Missing hsync: hold `i_hsync`=1 for 32+ clocks while locked. A timeout unlock occurs with `o_active`=0 from then on.
- Reset mid-frame while locked: `rst_n` low for 1 clock gives all outputs 0 the next cycle and state SEARCH. The lock sequence then repeats as in the first scenario.
- Error during ACQUIRE after 1 good frame: good-count clears, and lock takes 2 more clean frames.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers column/row from active-low hsync/vsync, locks to the
// expected frame timing, and emits active-video enable, coordinates and blanked RGB.
module vga_sync_decoder #(
    parameter int VIDEO_WIDTH      = 3,
    parameter int CNT_WIDTH        = 10,
    parameter int TOTAL_COLS       = 800,
    parameter int TOTAL_ROWS       = 525,
    parameter int ACTIVE_COLS      = 640,
    parameter int ACTIVE_ROWS      = 480,
    parameter int FRONT_PORCH_HORZ = 18,
    parameter int BACK_PORCH_HORZ  = 50,
    parameter int FRONT_PORCH_VERT = 10,
    parameter int BACK_PORCH_VERT  = 33,
    parameter int LOCK_FRAMES      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    input  logic [VIDEO_WIDTH-1:0] i_r_val,
    input  logic [VIDEO_WIDTH-1:0] i_g_val,
    input  logic [VIDEO_WIDTH-1:0] i_b_val,
    output logic [VIDEO_WIDTH-1:0] o_r_val,
    output logic [VIDEO_WIDTH-1:0] o_g_val,
    output logic [VIDEO_WIDTH-1:0] o_b_val,
    output logic [CNT_WIDTH-1:0]   o_col,
    output logic [CNT_WIDTH-1:0]   o_row,
    output logic                   o_active,
    output logic                   o_frame_start,
    output logic                   o_locked
);
    localparam logic [CNT_WIDTH-1:0] H_SYNC_COL = CNT_WIDTH'(ACTIVE_COLS + FRONT_PORCH_HORZ);
    localparam logic [CNT_WIDTH-1:0] V_SYNC_ROW = CNT_WIDTH'(ACTIVE_ROWS + FRONT_PORCH_VERT);
    localparam logic [CNT_WIDTH-1:0] COL_MAX    = CNT_WIDTH'(TOTAL_COLS - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_MAX    = CNT_WIDTH'(TOTAL_ROWS - 1);
    localparam logic [CNT_WIDTH-1:0] ACOLS      = CNT_WIDTH'(ACTIVE_COLS);
    localparam logic [CNT_WIDTH-1:0] AROWS      = CNT_WIDTH'(ACTIVE_ROWS);
    localparam int TMO = 2 * TOTAL_COLS;
    localparam int TW  = $clog2(TMO);
    localparam int GW  = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t                 state, state_n;
    logic                   hs_q, hs_p, vs_q, vs_p;
    logic [VIDEO_WIDTH-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
    logic [CNT_WIDTH-1:0]   col, row, col_n, row_n, col_inc, row_inc;
    logic [GW-1:0]          good, good_n;
    logic [TW-1:0]          tcnt;
    logic                   err_since, err_q, h_seen;
    logic                   h_fall, v_fall, h_err, v_err, tmo, err, run, act;

    assign h_fall  = hs_p & ~hs_q;
    assign v_fall  = vs_p & ~vs_q;
    assign col_inc = (col == COL_MAX) ? '0 : col + CNT_WIDTH'(1);
    assign row_inc = (col != COL_MAX) ? row : ((row == ROW_MAX) ? '0 : row + CNT_WIDTH'(1));
    // Errors compare a sync edge against where the free-running counters would have gone.
    assign h_err   = h_fall && (col_inc != H_SYNC_COL);
    assign v_err   = v_fall && (row_inc != V_SYNC_ROW);
    assign tmo     = !h_fall && (tcnt == TW'(TMO - 1));
    assign err     = (state != SEARCH) && (h_err || v_err || tmo);
    assign run     = (state != SEARCH) || h_seen;
    assign act     = (state == LOCKED) && (col < ACOLS) && (row < AROWS);

    always_comb begin
        state_n = state;
        good_n  = good;
        col_n   = h_fall ? H_SYNC_COL : (run ? col_inc : '0);
        row_n   = v_fall ? V_SYNC_ROW : ((state == SEARCH) ? '0 : row_inc);
        case (state)
            SEARCH: begin
                if (v_fall) begin
                    state_n = ACQUIRE;
                    good_n  = '0;
                end
            end
            ACQUIRE: begin
                if (v_fall) begin
                    if (err || err_since) begin
                        good_n = '0;
                    end else if (good == GW'(LOCK_FRAMES - 1)) begin
                        state_n = LOCKED;
                        good_n  = '0;
                    end else begin
                        good_n = good + GW'(1);
                    end
                end
            end
            // Leave one cycle late so the offending sample still shows as locked.
            LOCKED:  if (err_q) state_n = SEARCH;
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_q <= 1'b1; hs_p <= 1'b1; vs_q <= 1'b1; vs_p <= 1'b1;
            r_q <= '0; g_q <= '0; b_q <= '0;
            r_d <= '0; g_d <= '0; b_d <= '0;
            state <= SEARCH;
            col <= '0; row <= '0; good <= '0; tcnt <= '0;
            err_since <= 1'b0; err_q <= 1'b0; h_seen <= 1'b0;
            o_r_val <= '0; o_g_val <= '0; o_b_val <= '0;
            o_col <= '0; o_row <= '0;
            o_active <= 1'b0; o_frame_start <= 1'b0; o_locked <= 1'b0;
        end else begin
            hs_q <= i_hsync; hs_p <= hs_q;
            vs_q <= i_vsync; vs_p <= vs_q;
            r_q <= i_r_val; g_q <= i_g_val; b_q <= i_b_val;
            r_d <= r_q; g_d <= g_q; b_d <= b_q;
            state <= state_n;
            col <= col_n;
            row <= row_n;
            good <= good_n;
            tcnt <= (h_fall || tmo) ? '0 : tcnt + TW'(1);
            err_q <= err;
            err_since <= (state != SEARCH) && !v_fall && (err_since || err);
            h_seen <= (state == SEARCH) && (h_seen || h_fall);
            o_r_val <= act ? r_d : '0;
            o_g_val <= act ? g_d : '0;
            o_b_val <= act ? b_d : '0;
            o_col <= col;
            o_row <= row;
            o_active <= act;
            o_frame_start <= (state == LOCKED) && (col == '0) && (row == '0);
            o_locked <= (state == LOCKED);
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder with a 16x12 frame; expected values are hand-derived
// sample indices (sample k shows at the outputs after step k+2).
module tb_vga_sync_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_hsync = 1'b1, i_vsync = 1'b1;
    logic [2:0] i_r_val = '0, i_g_val = '0, i_b_val = '0;
    logic [2:0] o_r_val, o_g_val, o_b_val;
    logic [9:0] o_col, o_row;
    logic       o_active, o_frame_start, o_locked;

    int n_chk = 0, n_fail = 0;
    int k = 0, kd = 0;

    vga_sync_decoder #(
        .VIDEO_WIDTH(3), .CNT_WIDTH(10), .TOTAL_COLS(16), .TOTAL_ROWS(12),
        .ACTIVE_COLS(8), .ACTIVE_ROWS(6), .FRONT_PORCH_HORZ(2), .BACK_PORCH_HORZ(3),
        .FRONT_PORCH_VERT(1), .BACK_PORCH_VERT(2), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_hsync(i_hsync), .i_vsync(i_vsync),
        .i_r_val(i_r_val), .i_g_val(i_g_val), .i_b_val(i_b_val),
        .o_r_val(o_r_val), .o_g_val(o_g_val), .o_b_val(o_b_val),
        .o_col(o_col), .o_row(o_row), .o_active(o_active),
        .o_frame_start(o_frame_start), .o_locked(o_locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (step %0d)", tag, got, exp, kd);
        end
    endtask

    // Drive sample k: hsync low cols 10..12, vsync low rows 7..9, RGB = column.
    // Early-hsync samples and a hsync-suppression window are injected by index.
    task automatic step();
        int c, r;
        logic hs;
        c  = k % 16;
        r  = (k / 16) % 12;
        hs = !(c >= 10 && c <= 12);
        if (k == 793 || k == 2841) hs = 1'b0;
        if (k >= 1360 && k < 1408) hs = 1'b1;
        i_hsync = hs;
        i_vsync = !(r >= 7 && r <= 9);
        i_r_val = 3'(c);
        i_g_val = 3'(c);
        i_b_val = 3'(c);
        @(posedge clk);
        #1;
        kd = k;
        k++;
    endtask

    task automatic run_to(input int n);
        while (k <= n) step();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, 32'(o_locked), 0);
        chk({tag, "_active"}, 32'(o_active), 0);
        chk({tag, "_col"}, 32'(o_col), 0);
        chk({tag, "_row"}, 32'(o_row), 0);
        chk({tag, "_fs"}, 32'(o_frame_start), 0);
        chk({tag, "_rgb"}, 32'({o_r_val, o_g_val, o_b_val}), 0);
    endtask

    initial begin
        int act_cnt, fs_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Lock rises 2 clocks after the third vsync fall (sample 496).
        run_to(497);
        chk("lock_pre", 32'(o_locked), 0);
        step();
        chk("lock_rise", 32'(o_locked), 1);
        chk("lock_row", 32'(o_row), 7);
        chk("lock_col", 32'(o_col), 0);

        // One locked frame: samples 576..767.
        run_to(577);
        act_cnt = 0;
        fs_cnt  = 0;
        repeat (192) begin
            step();
            if (o_active) act_cnt++;
            if (o_frame_start) fs_cnt++;
            if (kd == 578) begin
                chk("fs_pulse", 32'(o_frame_start), 1);
                chk("fs_col", 32'(o_col), 0);
            end
            if (kd == 613) begin
                chk("pix_r", 32'(o_r_val), 3);
                chk("pix_b", 32'(o_b_val), 3);
                chk("pix_row", 32'(o_row), 2);
                chk("pix_act", 32'(o_active), 1);
            end
            if (kd == 619) begin
                chk("porch_r", 32'(o_r_val), 0);
                chk("porch_act", 32'(o_active), 0);
                chk("porch_col", 32'(o_col), 9);
            end
        end
        chk("frame_active", 32'(act_cnt), 48);
        chk("frame_fs", 32'(fs_cnt), 1);

        // Early hsync at sample 793.
        run_to(795);
        chk("early_col", 32'(o_col), 10);
        chk("early_still_locked", 32'(o_locked), 1);
        step();
        chk("early_unlock", 32'(o_locked), 0);
        chk("early_active", 32'(o_active), 0);
        run_to(1265);
        chk("relock_pre", 32'(o_locked), 0);
        step();
        chk("relock", 32'(o_locked), 1);
        chk("relock_row", 32'(o_row), 7);

        // Missing hsync: timeout on sample 1386.
        run_to(1388);
        chk("tmo_pre", 32'(o_locked), 1);
        step();
        chk("tmo_unlock", 32'(o_locked), 0);
        act_cnt = 0;
        while (k <= 1500) begin
            step();
            if (o_active || o_r_val != 0) act_cnt++;
        end
        chk("tmo_quiet", 32'(act_cnt), 0);

        // Reset mid-frame while locked.
        run_to(1972);
        chk("rst_pre", 32'(o_locked), 1);
        rst_n = 1'b0;
        step();
        chk_zero("midrst");
        rst_n = 1'b1;
        run_to(2417);
        chk("rst_relock_pre", 32'(o_locked), 0);
        step();
        chk("rst_relock", 32'(o_locked), 1);

        // Error during ACQUIRE after one good frame (vfalls 2608, 2800; error 2841).
        run_to(2499);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run_to(2994);
        chk("acq_err_nolock", 32'(o_locked), 0);
        run_to(3377);
        chk("acq_relock_pre", 32'(o_locked), 0);
        step();
        chk("acq_relock", 32'(o_locked), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
